// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: register addresses, ExcCode values, Status/Cause bit fields.
// Imported by cp0_ctrl and cp0_timer (timer present only when CP0_TIMER_EN is defined).
package cp0_ctrl_pkg;

    localparam logic       MEM_READ  = 1'b0;
    localparam logic       MEM_WRITE = 1'b1;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;

    // BadVAddr only carries meaning for address-error exceptions
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with IP7 latch; whole module exists only when CP0_TIMER_EN is defined.
// Count free-runs and wraps; a software write to Count replaces that cycle's increment.
`ifdef CP0_TIMER_EN
module cp0_timer
    import cp0_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_count,
    input  logic        i_wr_compare,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ip7
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ip7;
    logic [31:0] w_count_inc;

    assign w_count_inc = r_count + 32'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_compare <= '0;
            r_ip7     <= 1'b0;
        end else begin
            r_count <= i_wr_count ? i_wr_data : w_count_inc;
            if (i_wr_compare)
                r_compare <= i_wr_data;
            // a Compare write acknowledges the timer and beats a match in the same cycle
            if (i_wr_compare)
                r_ip7 <= 1'b0;
            else if (!i_wr_count && (w_count_inc == r_compare))
                r_ip7 <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ip7     = r_ip7;

endmodule
`endif

// File: rtl/cp0_ctrl.sv
// CP0 register file, exception/ERET sequencer and interrupt merge for the 5-stage core.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN; otherwise they read 0.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          REG_ADDR_WIDTH = 5,
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0380
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cp0_reg_rw,
    input  logic [REG_ADDR_WIDTH-1:0] cp0_reg_write_addr,
    input  logic [DATA_WIDTH-1:0]     cp0_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] cp0_reg_read_addr,
    output logic [DATA_WIDTH-1:0]     cp0_reg_read,
    input  logic                      exc_valid,
    input  logic [4:0]                exc_code,
    input  logic [DATA_WIDTH-1:0]     exc_pc,
    input  logic                      exc_in_delay_slot,
    input  logic [DATA_WIDTH-1:0]     exc_badvaddr,
    input  logic                      eret,
    input  logic [5:0]                int_hw,
    output logic                      int_req,
    output logic                      flush,
    output logic [DATA_WIDTH-1:0]     redirect_pc,
    output logic                      timer_int
);

    logic [31:0] r_badvaddr;
    logic [31:0] r_epc;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic        r_int_req;
    logic        r_flush;
    logic [31:0] r_redirect_pc;

    logic        w_mtc0;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ip7;

    // exceptions and ERET own CP0 in their cycle; a coincident MTC0 is dropped
    assign w_mtc0 = (cp0_reg_rw == MEM_WRITE) && !exc_valid && !eret;

`ifdef CP0_TIMER_EN
    logic w_wr_count;
    logic w_wr_compare;

    assign w_wr_count   = w_mtc0 && (cp0_reg_write_addr == CP0_REG_COUNT);
    assign w_wr_compare = w_mtc0 && (cp0_reg_write_addr == CP0_REG_COMPARE);

    cp0_timer u_cp0_timer (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_count   (w_wr_count),
        .i_wr_compare (w_wr_compare),
        .i_wr_data    (cp0_reg_write),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ip7        (w_ip7)
    );
`else
    assign w_count   = '0;
    assign w_compare = '0;
    assign w_ip7     = 1'b0;
`endif

    assign w_status = {16'b0, r_im, 6'b0, r_exl, r_ie};
    // the timer shares IP7 (bit 15) with the top hardware line
    assign w_cause  = {r_bd, 15'b0, r_ip_hw[5] | w_ip7, r_ip_hw[4:0], r_ip_sw,
                       1'b0, r_exccode, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr    <= '0;
            r_epc         <= '0;
            r_im          <= '0;
            r_exl         <= 1'b0;
            r_ie          <= 1'b0;
            r_bd          <= 1'b0;
            r_exccode     <= '0;
            r_ip_hw       <= '0;
            r_ip_sw       <= '0;
            r_int_req     <= 1'b0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_ip_hw   <= int_hw;
            r_int_req <= r_ie & ~r_exl & (|(w_cause[15:8] & r_im));
            r_flush   <= exc_valid | eret;
            if (exc_valid) begin
                if (!r_exl) begin
                    r_epc <= exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
                    r_bd  <= exc_in_delay_slot;
                end
                r_exl         <= 1'b1;
                r_exccode     <= exc_code;
                r_redirect_pc <= EXC_VECTOR;
                if (is_addr_exc(exc_code))
                    r_badvaddr <= exc_badvaddr;
            end else if (eret) begin
                r_exl         <= 1'b0;
                r_redirect_pc <= r_epc;
            end else if (w_mtc0) begin
                case (cp0_reg_write_addr)
                    CP0_REG_BADVADDR: r_badvaddr <= cp0_reg_write;
                    CP0_REG_STATUS: begin
                        r_im  <= cp0_reg_write[15:8];
                        r_exl <= cp0_reg_write[STATUS_EXL];
                        r_ie  <= cp0_reg_write[STATUS_IE];
                    end
                    CP0_REG_CAUSE:    r_ip_sw <= cp0_reg_write[9:8];
                    CP0_REG_EPC:      r_epc   <= cp0_reg_write;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cp0_reg_read = '0;
        case (cp0_reg_read_addr)
            CP0_REG_BADVADDR: cp0_reg_read = r_badvaddr;
            CP0_REG_COUNT:    cp0_reg_read = w_count;
            CP0_REG_COMPARE:  cp0_reg_read = w_compare;
            CP0_REG_STATUS:   cp0_reg_read = w_status;
            CP0_REG_CAUSE:    cp0_reg_read = w_cause;
            CP0_REG_EPC:      cp0_reg_read = r_epc;
            default:          cp0_reg_read = '0;
        endcase
    end

    assign int_req     = r_int_req;
    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;
    assign timer_int   = w_ip7;

endmodule
